// File: rtl/rs_corrector_if.sv
// Byte stream and decoder result bundle between the RS(255,251) decoder and the corrector.
// master drives the codeword bytes and decoder results; slave is the corrector.
interface rs_corrector_if;
   logic       din_val;
   logic       din_sop;
   logic       din_eop;
   logic [7:0] din;
   logic [7:0] el1;
   logic [7:0] el2;
   logic [7:0] ev1;
   logic [7:0] ev2;
   logic [1:0] error_num;
   logic       dec_done;
   logic       dec_fail;
   logic       dout_val;
   logic       dout_sop;
   logic       dout_eop;
   logic [7:0] dout;
   logic       dout_fail;
   logic [1:0] dout_corr;
   logic       ovf;
   logic       busy;

   modport master (
      output din_val, din_sop, din_eop, din, el1, el2, ev1, ev2, error_num, dec_done, dec_fail,
      input  dout_val, dout_sop, dout_eop, dout, dout_fail, dout_corr, ovf, busy
   );

   modport slave (
      input  din_val, din_sop, din_eop, din, el1, el2, ev1, ev2, error_num, dec_done, dec_fail,
      output dout_val, dout_sop, dout_eop, dout, dout_fail, dout_corr, ovf, busy
   );
endinterface

// File: rtl/rs_corrector.sv
// Buffers RS(255,251) codewords in a two-bank ping-pong RAM, pairs each with its decoder
// result and streams the codeword out with the reported error values XORed in.
module rs_corrector #(
   parameter int N            = 255,
   parameter int K            = 251,
   parameter bit STRIP_PARITY = 1'b0
) (
   input logic           clk,
   input logic           rst,
   rs_corrector_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, STREAM} rd_state_e;

   typedef struct packed {
      logic [7:0] el1;
      logic [7:0] el2;
      logic [7:0] ev1;
      logic [7:0] ev2;
      logic [1:0] num;
      logic       fail;
   } result_t;

   localparam logic [7:0] WR_LAST = 8'(N - 1);
   localparam logic [7:0] RD_LAST = STRIP_PARITY ? 8'(K - 1) : 8'(N - 1);

   // Bank b occupies addresses {b, index}.
   logic [7:0] mem [0:511];
   logic [7:0] rdata_q;

   logic       wr_active_q, wr_active_d;
   logic       wr_bank_q, wr_bank_d;
   logic [7:0] wr_idx_q, wr_idx_d;
   logic       next_bank_q, next_bank_d;
   logic [1:0] full_q, full_d;
   logic [1:0] bad_q, bad_d;
   logic       wr_hit;
   logic       wr_sel;
   logic [7:0] wr_at;
   logic       wr_drop;
   logic       ovf_q;

   result_t    fifo_q [2];
   logic [1:0] fifo_cnt_q;
   logic       fifo_wp_q;
   logic       fifo_rp_q;
   logic       fifo_push;

   rd_state_e  state_q, state_d;
   logic [7:0] rd_idx_q, rd_idx_d;
   logic       rd_bank_q, rd_bank_d;
   result_t    res_q, res_d;
   logic       rd_bad_q, rd_bad_d;
   logic       pop;
   logic       rd_en;
   logic       free_rd;

   logic       s1_val_q, s1_sop_q, s1_eop_q;
   logic [7:0] s1_idx_q;
   logic       corr_en;
   logic [7:0] corr;

   logic       dout_val_q, dout_sop_q, dout_eop_q, dout_fail_q;
   logic [7:0] dout_q;
   logic [1:0] dout_corr_q;

   // Write side: a new sop takes the next bank in strict alternation; sop mid-frame restarts.
   always_comb begin
      wr_active_d = wr_active_q;
      wr_bank_d   = wr_bank_q;
      wr_idx_d    = wr_idx_q;
      next_bank_d = next_bank_q;
      full_d      = full_q;
      bad_d       = bad_q;
      wr_hit      = 1'b0;
      wr_sel      = wr_bank_q;
      wr_at       = wr_idx_q + 8'd1;
      wr_drop     = 1'b0;
      if (free_rd) begin
         full_d[rd_bank_q] = 1'b0;
      end
      if (bus.din_val) begin
         if (bus.din_sop && !wr_active_q) begin
            if (!full_q[next_bank_q]) begin
               wr_hit      = 1'b1;
               wr_sel      = next_bank_q;
               wr_at       = 8'd0;
               next_bank_d = ~next_bank_q;
            end else begin
               wr_drop = 1'b1;
            end
         end else if (bus.din_sop) begin
            wr_hit = 1'b1;
            wr_at  = 8'd0;
         end else if (wr_active_q) begin
            wr_hit = 1'b1;
         end
      end
      if (wr_hit) begin
         wr_bank_d   = wr_sel;
         wr_idx_d    = wr_at;
         wr_active_d = 1'b1;
         if (bus.din_eop || wr_at == WR_LAST) begin
            wr_active_d   = 1'b0;
            full_d[wr_sel] = 1'b1;
            bad_d[wr_sel]  = (wr_at != WR_LAST);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_hit) begin
         mem[{wr_sel, wr_at}] <= bus.din;
      end
      if (rd_en) begin
         rdata_q <= mem[{rd_bank_q, rd_idx_q}];
      end
   end

   assign fifo_push = bus.dec_done && (fifo_cnt_q != 2'd2);

   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_q[fifo_wp_q] <= {bus.el1, bus.el2, bus.ev1, bus.ev2, bus.error_num, bus.dec_fail};
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_idx_d  = rd_idx_q;
      rd_bank_d = rd_bank_q;
      res_d     = res_q;
      rd_bad_d  = rd_bad_q;
      pop       = 1'b0;
      rd_en     = 1'b0;
      free_rd   = 1'b0;
      case (state_q)
         IDLE: begin
            if (full_q[rd_bank_q] && fifo_cnt_q != 2'd0) begin
               pop      = 1'b1;
               res_d    = fifo_q[fifo_rp_q];
               rd_bad_d = bad_q[rd_bank_q];
               rd_idx_d = 8'd0;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            rd_en    = 1'b1;
            rd_idx_d = rd_idx_q + 8'd1;
            state_d  = STREAM;
         end
         STREAM: begin
            rd_en    = 1'b1;
            rd_idx_d = rd_idx_q + 8'd1;
            if (rd_idx_q == RD_LAST) begin
               free_rd   = 1'b1;
               rd_bank_d = ~rd_bank_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // res_q only changes on leaving IDLE, after the previous frame's last byte has been read.
   always_comb begin
      corr_en = !res_q.fail && !rd_bad_q;
      corr    = 8'h00;
      if (corr_en && res_q.num >= 2'd1 && s1_idx_q == res_q.el1) begin
         corr = corr ^ res_q.ev1;
      end
      if (corr_en && res_q.num == 2'd2 && s1_idx_q == res_q.el2) begin
         corr = corr ^ res_q.ev2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_active_q <= 1'b0;
         wr_bank_q   <= 1'b0;
         wr_idx_q    <= 8'd0;
         next_bank_q <= 1'b0;
         full_q      <= 2'b00;
         bad_q       <= 2'b00;
         ovf_q       <= 1'b0;
         fifo_cnt_q  <= 2'd0;
         fifo_wp_q   <= 1'b0;
         fifo_rp_q   <= 1'b0;
         state_q     <= IDLE;
         rd_idx_q    <= 8'd0;
         rd_bank_q   <= 1'b0;
         res_q       <= '0;
         rd_bad_q    <= 1'b0;
         s1_val_q    <= 1'b0;
         s1_sop_q    <= 1'b0;
         s1_eop_q    <= 1'b0;
         s1_idx_q    <= 8'd0;
         dout_val_q  <= 1'b0;
         dout_sop_q  <= 1'b0;
         dout_eop_q  <= 1'b0;
         dout_q      <= 8'h00;
         dout_fail_q <= 1'b0;
         dout_corr_q <= 2'd0;
      end else begin
         wr_active_q <= wr_active_d;
         wr_bank_q   <= wr_bank_d;
         wr_idx_q    <= wr_idx_d;
         next_bank_q <= next_bank_d;
         full_q      <= full_d;
         bad_q       <= bad_d;
         if (wr_drop || (bus.dec_done && fifo_cnt_q == 2'd2)) begin
            ovf_q <= 1'b1;
         end
         if (fifo_push) begin
            fifo_wp_q <= ~fifo_wp_q;
         end
         if (pop) begin
            fifo_rp_q <= ~fifo_rp_q;
         end
         fifo_cnt_q  <= fifo_cnt_q + {1'b0, fifo_push} - {1'b0, pop};
         state_q     <= state_d;
         rd_idx_q    <= rd_idx_d;
         rd_bank_q   <= rd_bank_d;
         res_q       <= res_d;
         rd_bad_q    <= rd_bad_d;
         s1_val_q    <= rd_en;
         s1_sop_q    <= rd_en && (rd_idx_q == 8'd0);
         s1_eop_q    <= rd_en && (rd_idx_q == RD_LAST);
         s1_idx_q    <= rd_idx_q;
         dout_val_q  <= s1_val_q;
         dout_sop_q  <= s1_val_q && s1_sop_q;
         dout_eop_q  <= s1_val_q && s1_eop_q;
         dout_q      <= s1_val_q ? (rdata_q ^ corr) : 8'h00;
         dout_fail_q <= s1_val_q && s1_eop_q && (res_q.fail || rd_bad_q);
         dout_corr_q <= (s1_val_q && s1_eop_q && corr_en) ? res_q.num : 2'd0;
      end
   end

   assign bus.dout_val  = dout_val_q;
   assign bus.dout_sop  = dout_sop_q;
   assign bus.dout_eop  = dout_eop_q;
   assign bus.dout      = dout_q;
   assign bus.dout_fail = dout_fail_q;
   assign bus.dout_corr = dout_corr_q;
   assign bus.ovf       = ovf_q;
   assign bus.busy      = full_q[0] || full_q[1] || wr_active_q;
endmodule

// File: tb/tb_rs_corrector.sv
// Directed bench for rs_corrector: one full-length and one parity-stripping instance share
// the same input stream; emitted frames are collected and compared against hand-built images.
module tb_rs_corrector;
   localparam int N = 255;
   localparam int K = 251;

   typedef struct {
      int start;
      int len;
      int fail;
      int corr;
      int sop_ok;
      int first_cyc;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         dec_cyc = 0;
   logic [7:0] tx_b  [256];
   logic [7:0] exp_b [256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rs_corrector_if bus ();
   rs_corrector_if bus_s ();

   assign bus_s.din_val   = bus.din_val;
   assign bus_s.din_sop   = bus.din_sop;
   assign bus_s.din_eop   = bus.din_eop;
   assign bus_s.din       = bus.din;
   assign bus_s.el1       = bus.el1;
   assign bus_s.el2       = bus.el2;
   assign bus_s.ev1       = bus.ev1;
   assign bus_s.ev2       = bus.ev2;
   assign bus_s.error_num = bus.error_num;
   assign bus_s.dec_done  = bus.dec_done;
   assign bus_s.dec_fail  = bus.dec_fail;

   rs_corrector #(.N(N), .K(K), .STRIP_PARITY(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   rs_corrector #(.N(N), .K(K), .STRIP_PARITY(1'b1)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   logic [1:0]      mval, msop, meop, mfail;
   logic [1:0][7:0] mdat;
   logic [1:0][1:0] mcorr;
   assign mval  = {bus_s.dout_val, bus.dout_val};
   assign msop  = {bus_s.dout_sop, bus.dout_sop};
   assign meop  = {bus_s.dout_eop, bus.dout_eop};
   assign mfail = {bus_s.dout_fail, bus.dout_fail};
   assign mdat  = {bus_s.dout, bus.dout};
   assign mcorr = {bus_s.dout_corr, bus.dout_corr};

   for (genvar gi = 0; gi < 2; gi++) begin : g_mon
      logic [7:0] bq [$];
      frame_t     fq [$];
      int         st = 0;
      int         fc = 0;
      int         sok = 0;
      int         infr = 0;
      always @(negedge clk) begin
         frame_t f;
         if (rst) begin
            infr = 0;
         end else if (mval[gi]) begin
            if (msop[gi] || infr == 0) begin
               st   = bq.size();
               fc   = cyc;
               sok  = int'(msop[gi]);
               infr = 1;
            end
            bq.push_back(mdat[gi]);
            if (meop[gi]) begin
               f.start     = st;
               f.len       = bq.size() - st;
               f.fail      = int'(mfail[gi]);
               f.corr      = int'(mcorr[gi]);
               f.sop_ok    = sok;
               f.first_cyc = fc;
               fq.push_back(f);
               infr = 0;
            end
         end
      end
   end

   function automatic int nframes(input int d);
      if (d == 0) return g_mon[0].fq.size();
      return g_mon[1].fq.size();
   endfunction

   function automatic frame_t getf(input int d, input int i);
      if (d == 0) return g_mon[0].fq[i];
      return g_mon[1].fq[i];
   endfunction

   function automatic logic [7:0] getb(input int d, input int i);
      if (d == 0) return g_mon[0].bq[i];
      return g_mon[1].bq[i];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input int len);
      for (int i = 0; i < len; i++) begin
         bus.din_val = 1'b1;
         bus.din_sop = (i == 0);
         bus.din_eop = (i == len - 1);
         bus.din     = tx_b[i];
         tick();
      end
      bus.din_val = 1'b0;
      bus.din_sop = 1'b0;
      bus.din_eop = 1'b0;
   endtask

   task automatic dec(input int e1, input int e2, input int v1, input int v2, input int num, input int fl);
      bus.el1       = 8'(e1);
      bus.el2       = 8'(e2);
      bus.ev1       = 8'(v1);
      bus.ev2       = 8'(v2);
      bus.error_num = 2'(num);
      bus.dec_fail  = fl[0];
      bus.dec_done  = 1'b1;
      tick();
      dec_cyc       = cyc;
      bus.dec_done  = 1'b0;
   endtask

   task automatic wait_frames(input string tag, input int n);
      for (int c = 0; c < 3000 && (nframes(0) < n || nframes(1) < n); c++) tick();
      chk({tag, " frames"}, nframes(0), n);
      chk({tag, " frames strip"}, nframes(1), n);
      repeat (2) tick();
   endtask

   task automatic chk_frame(input string tag, input int d, input int fi, input int len,
                            input int fl, input int corr, input int ncmp);
      frame_t f;
      int     bad = 0;
      if (nframes(d) <= fi) begin
         chk({tag, " present"}, nframes(d), fi + 1);
         return;
      end
      f = getf(d, fi);
      chk({tag, " len"}, f.len, len);
      chk({tag, " fail"}, f.fail, fl);
      chk({tag, " corr"}, f.corr, corr);
      chk({tag, " sop"}, f.sop_ok, 1);
      for (int i = 0; i < ncmp; i++) begin
         if (getb(d, f.start + i) !== exp_b[i]) bad++;
      end
      chk({tag, " bad bytes"}, bad, 0);
   endtask

   task automatic fill_ramp(input logic [7:0] key);
      for (int i = 0; i < 256; i++) begin
         tx_b[i]  = 8'(i) ^ key;
         exp_b[i] = 8'(i) ^ key;
      end
   endtask

   initial begin
      bus.din_val   = 1'b0;
      bus.din_sop   = 1'b0;
      bus.din_eop   = 1'b0;
      bus.din       = 8'h00;
      bus.el1       = 8'h00;
      bus.el2       = 8'h00;
      bus.ev1       = 8'h00;
      bus.ev2       = 8'h00;
      bus.error_num = 2'd0;
      bus.dec_done  = 1'b0;
      bus.dec_fail  = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset outs", int'({bus.dout_val, bus.dout_sop, bus.dout_eop, bus.dout, bus.dout_fail, bus.dout_corr}), 0);
      chk("reset busy", bus.busy, 0);
      chk("reset ovf", bus.ovf, 0);
      chk("reset outs strip", int'({bus_s.dout_val, bus_s.dout, bus_s.busy, bus_s.ovf}), 0);

      // clean codeword, result arrives long after eop
      fill_ramp(8'h00);
      send(N);
      chk("t1 busy", bus.busy, 1);
      repeat (300) tick();
      chk("t1 held", nframes(0) + nframes(1), 0);
      dec(0, 0, 0, 0, 0, 0);
      wait_frames("t1", 1);
      chk_frame("t1", 0, 0, N, 0, 0, N);
      chk_frame("t1 strip", 1, 0, K, 0, 0, K);
      chk("t1 latency", getf(0, 0).first_cyc - dec_cyc, 3);
      chk("t1 latency strip", getf(1, 0).first_cyc - dec_cyc, 3);
      chk("t1 idle busy", bus.busy, 0);

      // single error at byte 10
      fill_ramp(8'h00);
      tx_b[10] = 8'h0A ^ 8'h5C;
      send(N);
      dec(10, 0, 8'h5C, 0, 1, 0);
      wait_frames("t2", 2);
      chk_frame("t2", 0, 1, N, 0, 1, N);
      chk_frame("t2 strip", 1, 1, K, 0, 1, K);

      // two errors at the first and last byte
      fill_ramp(8'h00);
      tx_b[0]   = 8'h00 ^ 8'h11;
      tx_b[254] = 8'hFE ^ 8'h22;
      send(N);
      dec(0, 254, 8'h11, 8'h22, 2, 0);
      wait_frames("t3", 3);
      chk_frame("t3", 0, 2, N, 0, 2, N);
      chk_frame("t3 strip", 1, 2, K, 0, 2, K);

      // uncorrectable: reported error must not be applied
      fill_ramp(8'h00);
      send(N);
      dec(5, 0, 8'hFF, 0, 1, 1);
      wait_frames("t4", 4);
      chk_frame("t4", 0, 3, N, 1, 0, N);
      chk_frame("t4 strip", 1, 3, K, 1, 0, K);

      // three back-to-back codewords, no results yet: third is dropped
      fill_ramp(8'h00);
      send(N);
      fill_ramp(8'h55);
      send(N);
      fill_ramp(8'hAA);
      send(N);
      chk("t5 ovf", bus.ovf, 1);
      chk("t5 ovf strip", bus_s.ovf, 1);
      chk("t5 busy", bus.busy, 1);
      chk("t5 held", nframes(0), 4);
      dec(0, 0, 0, 0, 0, 0);
      dec(0, 0, 0, 0, 0, 0);
      wait_frames("t5", 6);
      fill_ramp(8'h00);
      chk_frame("t5 a", 0, 4, N, 0, 0, N);
      chk_frame("t5 a strip", 1, 4, K, 0, 0, K);
      fill_ramp(8'h55);
      chk_frame("t5 b", 0, 5, N, 0, 0, N);
      chk_frame("t5 b strip", 1, 5, K, 0, 0, K);
      repeat (600) tick();
      chk("t5 no third", nframes(0), 6);
      chk("t5 no third strip", nframes(1), 6);

      // short codeword: marked bad, no correction
      fill_ramp(8'h00);
      send(200);
      dec(3, 0, 8'h77, 0, 1, 0);
      wait_frames("t6", 7);
      chk_frame("t6 short", 0, 6, N, 1, 0, 200);
      chk_frame("t6 short strip", 1, 6, K, 1, 0, 200);
      chk("t6 ovf sticky", bus.ovf, 1);

      // reset while streaming
      fill_ramp(8'h00);
      send(N);
      dec(0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 500 && !bus.dout_val; c++) tick();
      chk("t6 streaming", bus.dout_val, 1);
      repeat (20) tick();
      rst = 1'b1;
      tick();
      chk("t6 rst outs", int'({bus.dout_val, bus.dout_sop, bus.dout_eop, bus.dout, bus.dout_fail, bus.dout_corr}), 0);
      chk("t6 rst busy", bus.busy, 0);
      chk("t6 rst ovf", bus.ovf, 0);
      chk("t6 rst outs strip", int'({bus_s.dout_val, bus_s.dout, bus_s.busy, bus_s.ovf}), 0);
      rst = 1'b0;
      tick();

      // normal operation resumes after reset
      fill_ramp(8'h00);
      tx_b[100] = 8'd100 ^ 8'h81;
      send(N);
      dec(100, 0, 8'h81, 0, 1, 0);
      wait_frames("t7", 8);
      chk_frame("t7", 0, 7, N, 0, 1, N);
      chk_frame("t7 strip", 1, 7, K, 0, 1, K);
      chk("t7 ovf", bus.ovf, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
